// File: rtl/twiddle_apply_stage_pkg.sv
// Shared constants for twiddle_apply_stage: sample width, twiddle fraction bits,
// saturation bounds and the radix-4 twiddle address map (i_lo*i_hi mod 4).
package twiddle_apply_stage_pkg;

  localparam int SAMPLE_W     = 18;
  localparam int TW_FRAC_BITS = 10;
  localparam int PROD_W       = 2 * SAMPLE_W;
  localparam int SUM_W        = PROD_W + 1;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 18'sh1ffff;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 18'sh20000;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

  // Two bits per entry, entry index {i_hi, i_lo}, entry 15 in the MSBs.
  localparam logic [31:0] TW_ADDR_LUT = {
    2'd1, 2'd2, 2'd3, 2'd0,
    2'd2, 2'd0, 2'd2, 2'd0,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd0
  };

  function automatic logic [1:0] tw_addr_of(input logic [1:0] i_lo, input logic [1:0] i_hi);
    logic [4:0] base;
    base = {i_hi, i_lo, 1'b0};
    return TW_ADDR_LUT[base +: 2];
  endfunction

  // Returns {saturated, value}.
  function automatic logic [SAMPLE_W:0] sat_sample(input logic signed [SUM_W-1:0] v);
    if (v > SUM_W'(SAT_MAX))      return {1'b1, SAT_MAX};
    else if (v < SUM_W'(SAT_MIN)) return {1'b1, SAT_MIN};
    else                          return {1'b0, v[SAMPLE_W-1:0]};
  endfunction

endpackage

// File: rtl/twiddle_apply_stage_cmul_round_sat.sv
// S1/S2 of twiddle_apply_stage: 18x18 complex multiply, round half up, saturate to 18 bits.
// With TWIDDLE_APPLY_SAT_FLAG_EN defined it also keeps the sticky per-frame saturation flag.
module twiddle_apply_stage_cmul_round_sat
  import twiddle_apply_stage_pkg::*;
#(
  parameter int FRAC_BITS = TW_FRAC_BITS
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  in_valid,
  input  logic  in_last,
  input  cplx_t x,
  input  cplx_t tw,
`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
  input  logic  out_taken,
  output logic  sat_flag,
`endif
  output logic  out_valid,
  output logic  out_last,
  output cplx_t y
);

  localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) << (FRAC_BITS - 1);

  logic                     s1_valid, s1_last;
  logic signed [PROD_W-1:0] ac_q, bd_q, ad_q, bc_q;
  logic signed [SUM_W-1:0]  re_sum, im_sum, re_sh, im_sh;
  logic [SAMPLE_W:0]        re_sat, im_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      ac_q     <= '0;
      bd_q     <= '0;
      ad_q     <= '0;
      bc_q     <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      ac_q     <= PROD_W'(x.re) * PROD_W'(tw.re);
      bd_q     <= PROD_W'(x.im) * PROD_W'(tw.im);
      ad_q     <= PROD_W'(x.re) * PROD_W'(tw.im);
      bc_q     <= PROD_W'(x.im) * PROD_W'(tw.re);
    end
  end

  always_comb begin
    re_sum = SUM_W'(ac_q) - SUM_W'(bd_q);
    im_sum = SUM_W'(ad_q) + SUM_W'(bc_q);
    re_sh  = (re_sum + RND) >>> FRAC_BITS;
    im_sh  = (im_sum + RND) >>> FRAC_BITS;
    re_sat = sat_sample(re_sh);
    im_sat = sat_sample(im_sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      y         <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_last  <= s1_last;
      y.re      <= re_sat[SAMPLE_W-1:0];
      y.im      <= im_sat[SAMPLE_W-1:0];
    end
  end

`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
  // The departing last sample clears the flag; the sample loaded on that same edge still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (en) begin
      sat_flag <= ((out_taken && out_last) ? 1'b0 : sat_flag)
                | (s1_valid & (re_sat[SAMPLE_W] | im_sat[SAMPLE_W]));
    end
  end
`endif

endmodule

// File: rtl/twiddle_apply_stage.sv
// Radix-4 twiddle apply stage: drives the twiddle table address, aligns the returned twiddle
// with the sample and emits rounded, saturated products. Option: TWIDDLE_APPLY_SAT_FLAG_EN.
module twiddle_apply_stage
  import twiddle_apply_stage_pkg::*;
#(
  parameter int TW_FF     = 1,
  parameter int FRAC_BITS = TW_FRAC_BITS,
  parameter int FRAME_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] in_re,
  input  logic signed [SAMPLE_W-1:0] in_im,
  output logic [1:0]                 tw_addr,
  input  logic signed [SAMPLE_W-1:0] tw_re,
  input  logic signed [SAMPLE_W-1:0] tw_im,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_re,
  output logic signed [SAMPLE_W-1:0] out_im,
`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
  output logic                       sat_flag,
`endif
  output logic                       out_last
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  if (TW_FF < 0 || TW_FF > 1) begin : g_bad_tw_ff
    $error("twiddle_apply_stage: TW_FF must be 0 or 1");
  end
  if (FRAME_LEN < 16 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_frame_len
    $error("twiddle_apply_stage: FRAME_LEN must be a power of two >= 16");
  end

  logic             adv;
  logic [IDX_W-1:0] idx;
  logic             s0_valid, s0_last;
  cplx_t            s0_x;
  logic             a_valid, a_last;
  cplx_t            a_x, a_tw, tw_in, mult_tw, y;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  assign tw_in    = '{re: tw_re, im: tw_im};
  assign out_re   = y.re;
  assign out_im   = y.im;

  // S0: tw_addr is held with the sample so the table output stays tied to it while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s0_x     <= '0;
      idx      <= '0;
      tw_addr  <= 2'd0;
    end else if (adv) begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_x    <= '{re: in_re, im: in_im};
        s0_last <= (idx == IDX_W'(FRAME_LEN - 1));
        tw_addr <= tw_addr_of(idx[1:0], idx[3:2]);
        idx     <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_last  <= 1'b0;
      a_x     <= '0;
    end else if (adv) begin
      a_valid <= s0_valid;
      a_last  <= s0_last;
      a_x     <= s0_x;
    end
  end

  if (TW_FF == 0) begin : g_tw_comb
    always_ff @(posedge clk) begin
      if (rst)      a_tw <= '0;
      else if (adv) a_tw <= tw_in;
    end
    assign mult_tw = a_tw;
  end else begin : g_tw_reg
    // Registered table: its output matches the sample only in the cycle right after the
    // sample entered the align stage, so it is used live then and captured for later stalls.
    logic a_fresh;
    always_ff @(posedge clk) begin
      if (rst) begin
        a_fresh <= 1'b0;
        a_tw    <= '0;
      end else begin
        a_fresh <= adv;
        if (a_fresh) a_tw <= tw_in;
      end
    end
    assign mult_tw = a_fresh ? tw_in : a_tw;
  end

  twiddle_apply_stage_cmul_round_sat #(
    .FRAC_BITS (FRAC_BITS)
  ) u_cmul (
    .clk       (clk),
    .rst       (rst),
    .en        (adv),
    .in_valid  (a_valid),
    .in_last   (a_last),
    .x         (a_x),
    .tw        (mult_tw),
`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
    .out_taken (out_valid && out_ready),
    .sat_flag  (sat_flag),
`endif
    .out_valid (out_valid),
    .out_last  (out_last),
    .y         (y)
  );

endmodule

// File: tb/tb_twiddle_apply_stage.sv
// Bench for twiddle_apply_stage: TW_FF=0 and TW_FF=1 instances share stimulus and are
// checked by independent monitors against a scoreboard (sat_flag when TWIDDLE_APPLY_SAT_FLAG_EN).
`timescale 1ns/1ps
module tb_twiddle_apply_stage;

  localparam int FL = 16;

  typedef struct {
    logic signed [17:0] re;
    logic signed [17:0] im;
    logic               last;
    logic               sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [17:0] in_re = '0, in_im = '0;
  logic in_ready0, in_ready1;
  logic [1:0] tw_addr0, tw_addr1;
  logic signed [17:0] tw_re0, tw_im0, tw_re1, tw_im1;
  logic out_valid0, out_valid1, out_last0, out_last1;
  logic signed [17:0] out_re0, out_im0, out_re1, out_im1;
`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
  logic sat_flag0, sat_flag1;
  logic stk0 = 1'b0, stk1 = 1'b0;
`endif

  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int n_out0 = 0, n_out1 = 0;
  int mi = 0;
  int cyc = 0;
  logic tog_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  twiddle_apply_stage #(.TW_FF(0), .FRAC_BITS(10), .FRAME_LEN(FL)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr0), .tw_re(tw_re0), .tw_im(tw_im0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_re(out_re0), .out_im(out_im0),
`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
    .sat_flag(sat_flag0),
`endif
    .out_last(out_last0));

  twiddle_apply_stage #(.TW_FF(1), .FRAC_BITS(10), .FRAME_LEN(FL)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr1), .tw_re(tw_re1), .tw_im(tw_im1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_re(out_re1), .out_im(out_im1),
`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
    .sat_flag(sat_flag1),
`endif
    .out_last(out_last1));

  // Twiddle table: {re, im} for addresses 0..3.
  function automatic logic [35:0] tw_lut(input logic [1:0] a);
    case (a)
      2'd0:    return {18'h00400, 18'h00000};
      2'd1:    return {18'h00000, 18'h3fc00};
      2'd2:    return {18'h3fc00, 18'h3ffff};
      default: return {18'h3ffff, 18'h00400};
    endcase
  endfunction

  assign {tw_re0, tw_im0} = tw_lut(tw_addr0);
  always @(posedge clk) {tw_re1, tw_im1} <= tw_lut(tw_addr1);

  function automatic exp_t mk(input int re, input int im, input logic last, input logic sat);
    exp_t e;
    e.re = 18'(re); e.im = 18'(im); e.last = last; e.sat = sat;
    return e;
  endfunction

  function automatic exp_t model(input int re, input int im, input int idx);
    exp_t e;
    logic [35:0] t;
    longint c, d, pr, pi;
    int lo, hi;
    lo = idx % 4;
    hi = (idx / 4) % 4;
    t  = tw_lut(2'((lo * hi) % 4));
    c  = longint'($signed(t[35:18]));
    d  = longint'($signed(t[17:0]));
    pr = (longint'(re) * c - longint'(im) * d + 512) >>> 10;
    pi = (longint'(re) * d + longint'(im) * c + 512) >>> 10;
    e.sat = 1'b0;
    if (pr > 131071)  begin pr = 131071;  e.sat = 1'b1; end
    if (pr < -131072) begin pr = -131072; e.sat = 1'b1; end
    if (pi > 131071)  begin pi = 131071;  e.sat = 1'b1; end
    if (pi < -131072) begin pi = -131072; e.sat = 1'b1; end
    e.re = 18'(pr); e.im = 18'(pi); e.last = (idx == FL - 1);
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid0 && out_ready) begin
      n_out0++;
      if (q0.size() == 0) chk("out0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("out0_re", out_re0, e.re);
        chk("out0_im", out_im0, e.im);
        chk("out0_last", out_last0, e.last);
`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
        stk0 = stk0 | e.sat;
        chk("out0_sat_flag", sat_flag0, stk0);
        if (e.last) stk0 = 1'b0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid1 && out_ready) begin
      n_out1++;
      if (q1.size() == 0) chk("out1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("out1_re", out_re1, e.re);
        chk("out1_im", out_im1, e.im);
        chk("out1_last", out_last1, e.last);
`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
        stk1 = stk1 | e.sat;
        chk("out1_sat_flag", sat_flag1, stk1);
        if (e.last) stk1 = 1'b0;
`endif
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (tog_en) out_ready = 1'($urandom_range(0, 1));
  end

  // Holds the sample until accepted; returns #1 after the accepting edge.
  task automatic send(input int re, input int im, input exp_t e);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    in_valid = 1'b1; in_re = 18'(re); in_im = 18'(im);
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready0 & in_ready1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
    else begin
      q0.push_back(e); q1.push_back(e);
      mi = (mi + 1) % FL;
    end
  endtask

  task automatic send_m(input int re, input int im);
    send(re, im, model(re, im, mi));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    chk("drain_q0_left", q0.size(), 0);
    chk("drain_q1_left", q1.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int base0, base1, c0;

    // Reset state, sampled while rst is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_valid", out_valid0 | out_valid1, 0);
    chk("rst_out_re", out_re0, 0);
    chk("rst_out_im", out_im1, 0);
    chk("rst_out_last", out_last0 | out_last1, 0);
    chk("rst_tw_addr", {tw_addr0, tw_addr1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Hand vectors i=0..7, latency check on the first.
    send(1000, -500, mk(1000, -500, 0, 0));
    chk("tw_addr_i0", {tw_addr0, tw_addr1}, 0);
    @(negedge clk); chk("lat_c1", out_valid0 | out_valid1, 0);
    @(negedge clk); chk("lat_c2", out_valid0 | out_valid1, 0);
    @(negedge clk); chk("lat_c3", out_valid0 | out_valid1, 0);
    @(negedge clk); chk("lat_c4", out_valid0 & out_valid1, 1);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) send(0, 0, mk(0, 0, 0, 0));
    send(1000, -500, mk(-500, -1000, 0, 0));
    chk("tw_addr_i5", {tw_addr0, tw_addr1}, 4'b0101);
    send(1000, -500, mk(-1000, 499, 0, 0));
    chk("tw_addr_i6", {tw_addr0, tw_addr1}, 4'b1010);
    send(131071, 131071, mk(-131072, 130943, 0, 1));
    chk("tw_addr_i7", {tw_addr0, tw_addr1}, 4'b1111);
    drain();

    // Reset mid-frame with samples in flight.
    for (int k = 0; k < 7; k++) send_m(3000 * k - 9000, 12345 - 2000 * k);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready0 | in_ready1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); q1.delete(); mi = 0;
`ifdef TWIDDLE_APPLY_SAT_FLAG_EN
    stk0 = 1'b0; stk1 = 1'b0;
`endif
    chk("midrst_out_valid", out_valid0 | out_valid1, 0);

    // 32 samples with random backpressure and input gaps.
    base0 = n_out0; base1 = n_out1;
    send_m(777, -333);
    chk("midrst_tw_addr", {tw_addr0, tw_addr1}, 0);
    tog_en = 1'b1;
    for (int k = 1; k < 32; k++) begin
      if (k % 5 == 3) begin @(posedge clk); #1; end
      send_m(((k * 40503) % 262144) - 131072, ((k * 91193 + 7) % 262144) - 131072);
    end
    tog_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();
    chk("stream_count0", n_out0 - base0, 32);
    chk("stream_count1", n_out1 - base1, 32);

    // Back-to-back across a frame boundary: one sample per cycle.
    c0 = cyc;
    for (int k = 0; k < 24; k++) send_m(50000 - 4100 * k, 1700 * k - 20000);
    chk("throughput_cycles", cyc - c0, 24);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
